// File: rtl/alu_pkg.sv
// Shared opcode and state types for the execute-stage ALU and ALU control.
// The multiply opcode is only executed when ALU_MUL_EN is defined.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_MUL = 4'b1000
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier returning the low XLEN bits of a*b.
// done/product are valid for one cycle when the down-counter reaches zero.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  logic [XLEN-1:0] mcand_r;
  logic [XLEN-1:0] mplier_r;
  logic [XLEN-1:0] acc_r;
  logic [CW-1:0]   count_r;
  logic            run_r;
  logic [XLEN-1:0] step_s;

  // The last partial product is folded in combinationally so the result
  // is ready on the cycle the counter hits zero.
  always_comb begin
    step_s = acc_r;
    if (mplier_r[0]) begin
      step_s = acc_r + mcand_r;
    end else begin
      step_s = acc_r;
    end
  end

  assign done    = run_r && (count_r == {CW{1'b0}});
  assign product = step_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r  <= {XLEN{1'b0}};
      mplier_r <= {XLEN{1'b0}};
      acc_r    <= {XLEN{1'b0}};
      count_r  <= {CW{1'b0}};
      run_r    <= 1'b0;
    end else if (start) begin
      mcand_r  <= a;
      mplier_r <= b;
      acc_r    <= {XLEN{1'b0}};
      count_r  <= CW'(XLEN - 1);
      run_r    <= 1'b1;
    end else if (run_r) begin
      acc_r    <= step_s;
      mcand_r  <= {mcand_r[XLEN-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
      if (count_r == {CW{1'b0}}) begin
        run_r <= 1'b0;
      end else begin
        count_r <= count_r - CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with valid/ready handshake and registered result.
// Define ALU_MUL_EN to enable the iterative MUL (opcode 1000); otherwise it is illegal.
module alu_exec
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      operation,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  alu_state_e      state_r, state_n;
  logic [XLEN-1:0] result_r, result_n;
  logic            zero_r, zero_n;
  logic            illegal_r, illegal_n;
  logic            in_ready_s;
  logic            accept_s;
  alu_op_e         op_s;
  logic [XLEN-1:0] op_res_s;
  logic            op_ill_s;
  logic            op_mul_s;

`ifdef ALU_MUL_EN
  logic            mul_start_s;
  logic            mul_done_s;
  logic [XLEN-1:0] mul_prod_s;

  alu_mul_iter #(.XLEN(XLEN)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start_s),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );
`endif

  assign in_ready_s = (state_r == IDLE) || ((state_r == DONE) && out_ready);
  assign accept_s   = in_valid && in_ready_s;
  assign op_s       = alu_op_e'(operation);

  // Opcode decode and single-cycle datapath
  always_comb begin
    op_res_s = {XLEN{1'b0}};
    op_ill_s = 1'b0;
    op_mul_s = 1'b0;
    case (op_s)
      ALU_AND: op_res_s = op_a & op_b;
      ALU_OR:  op_res_s = op_a | op_b;
      ALU_ADD: op_res_s = op_a + op_b;
      ALU_SUB: op_res_s = op_a - op_b;
`ifdef ALU_MUL_EN
      ALU_MUL: op_mul_s = 1'b1;
`endif
      default: op_ill_s = 1'b1;
    endcase
  end

  // Next-state and result logic; an accept out of DONE behaves like one out of IDLE
  always_comb begin
    state_n   = state_r;
    result_n  = result_r;
    zero_n    = zero_r;
    illegal_n = illegal_r;
`ifdef ALU_MUL_EN
    mul_start_s = 1'b0;
`endif
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          if (op_mul_s) begin
            state_n   = BUSY;
            illegal_n = 1'b0;
`ifdef ALU_MUL_EN
            mul_start_s = 1'b1;
`endif
          end else begin
            state_n   = DONE;
            result_n  = op_res_s;
            zero_n    = (op_res_s == {XLEN{1'b0}});
            illegal_n = op_ill_s;
          end
        end else if ((state_r == DONE) && out_ready) begin
          state_n = IDLE;
        end else begin
          state_n = state_r;
        end
      end
`ifdef ALU_MUL_EN
      BUSY: begin
        if (mul_done_s) begin
          state_n   = DONE;
          result_n  = mul_prod_s;
          zero_n    = (mul_prod_s == {XLEN{1'b0}});
          illegal_n = 1'b0;
        end else begin
          state_n = BUSY;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      result_r  <= {XLEN{1'b0}};
      zero_r    <= 1'b1;
      illegal_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      result_r  <= result_n;
      zero_r    <= zero_n;
      illegal_r <= illegal_n;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = (state_r == DONE);
  assign result    = result_r;
  assign zero      = zero_r;
  assign illegal   = illegal_r;

endmodule
